// File: rtl/rede_in_feed.sv
// rede_in_feed: input staging buffer in front of the rede network wrapper.
// A producer pushes tagged samples into one FIFO per processor input channel.
// The wrapper's one-hot req_in strobe selects a channel: its head sample is
// presented on io_in and popped at the edge. Reading an empty channel shows
// the last value popped from that channel and raises a sticky underflow flag.
// A strobe with several bits set pops nothing and raises a sticky multi_req flag.
module rede_in_feed #(
   parameter int NUBITS = 31,
   parameter int NUIOIN = 4,
   parameter int FDEPTH = 8,
   parameter int CHW    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [NUBITS-1:0] wr_data,
   input  logic        [CHW-1:0]    wr_ch,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic        [NUIOIN-1:0] req_in,
   output logic signed [NUBITS-1:0] io_in,
   output logic        [NUIOIN-1:0] ch_empty,
   output logic        [NUIOIN-1:0] underflow,
   output logic                     multi_req,
   input  logic                     clr_err
);

   localparam int PW = $clog2(FDEPTH);
   localparam int CW = PW + 1;
   localparam int NTAG = 2 ** CHW;

   logic [NUIOIN-1:0]             full;
   logic [NTAG-1:0]               full_ext;
   logic [NUIOIN-1:0][NUBITS-1:0] head_data;
   logic [NUIOIN-1:0][NUBITS-1:0] hold_data;
   logic [NUIOIN-1:0]             req_m1;
   logic                          one_hot;
   logic                          multi;

   // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
   assign req_m1  = req_in - NUIOIN'(1);
   assign one_hot = (req_in != '0) && ((req_in & req_m1) == '0);
   assign multi   = (req_in & req_m1) != '0;

   // Tag values with no channel behind them read as permanently full,
   // which holds wr_ready low for them.
   for (genvar i = 0; i < NTAG; i++) begin : g_full
      if (i < NUIOIN) begin : g_real
         assign full_ext[i] = full[i];
      end else begin : g_pad
         assign full_ext[i] = 1'b1;
      end
   end

   // Back-pressure comes from registered counts only, so a pop in the same
   // cycle never frees space for a write to a full channel.
   assign wr_ready = ~full_ext[wr_ch];

   for (genvar k = 0; k < NUIOIN; k++) begin : g_ch
      logic [NUBITS-1:0] mem [FDEPTH];
      logic [PW-1:0]     head;
      logic [PW-1:0]     tail;
      logic [CW-1:0]     count;
      logic [NUBITS-1:0] hold;
      logic              uf;
      logic              rd_sel;
      logic              push;
      logic              pop;

      assign rd_sel = one_hot & req_in[k];
      assign push   = wr_valid & wr_ready & (wr_ch == CHW'(k));
      // A write to an empty channel is not visible to a pop in the same cycle.
      assign pop    = rd_sel & (count != '0);

      assign full[k]      = (count == CW'(FDEPTH));
      assign ch_empty[k]  = (count == '0);
      assign head_data[k] = mem[head];
      assign hold_data[k] = hold;
      assign underflow[k] = uf;

      // Sample storage written at the tail on an accepted push.
      // NOTE: the RAM has no reset; its contents are unreachable until written,
      // and leaving it out of the reset lets it map onto plain memory.
      always_ff @(posedge clk) begin
         if (push) mem[tail] <= wr_data;
      end

      // Pointers, count, hold register and sticky underflow for this channel.
      // NOTE: every register uses non-blocking assignment so all channels see
      // pre-edge values of each other and of the shared strobe decode.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            hold  <= '0;
            uf    <= 1'b0;
         end else begin
            if (push) tail <= tail + PW'(1);
            if (pop) begin
               head <= head + PW'(1);
               hold <= mem[head];
            end
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
            // Set wins over clear when both happen in one cycle.
            if (rd_sel && (count == '0)) uf <= 1'b1;
            else if (clr_err)            uf <= 1'b0;
         end
      end
   end

   // Sticky flag for strobes naming more than one channel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         multi_req <= 1'b0;
      else if (multi)   multi_req <= 1'b1;
      else if (clr_err) multi_req <= 1'b0;
   end

   // Present the selected head, or the hold register when that channel is empty.
   // NOTE: io_in gets a default before any branch so no latch is inferred.
   always_comb begin
      io_in = '0;
      if (one_hot) begin
         for (int k = 0; k < NUIOIN; k++) begin
            if (req_in[k]) io_in = ch_empty[k] ? hold_data[k] : head_data[k];
         end
      end
   end

endmodule

// File: tb/tb_rede_in_feed.sv
// Directed self-checking bench for rede_in_feed with hand-computed expectations.
module tb_rede_in_feed;

   localparam int NUBITS = 31;
   localparam int NUIOIN = 4;
   localparam int FDEPTH = 8;
   localparam int CHW    = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUBITS-1:0] wr_data;
   logic [CHW-1:0]    wr_ch;
   logic              wr_valid;
   logic              wr_ready;
   logic [NUIOIN-1:0] req_in;
   logic [NUBITS-1:0] io_in;
   logic [NUIOIN-1:0] ch_empty;
   logic [NUIOIN-1:0] underflow;
   logic              multi_req;
   logic              clr_err;

   int n_checks = 0;
   int n_fail   = 0;

   rede_in_feed #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .FDEPTH(FDEPTH), .CHW(CHW)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_data   (wr_data),
      .wr_ch     (wr_ch),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .req_in    (req_in),
      .io_in     (io_in),
      .ch_empty  (ch_empty),
      .underflow (underflow),
      .multi_req (multi_req),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch, input logic [NUBITS-1:0] d);
      wr_ch    = CHW'(ch);
      wr_data  = d;
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b0;
      wr_data  = '0;
      wr_ch    = '0;
      wr_valid = 1'b0;
      req_in   = '0;
      clr_err  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_empty", ch_empty, 4'b1111);
      check("rst_io", io_in, 0);
      check("rst_uf", underflow, 0);
      check("rst_multi", multi_req, 0);
      check("rst_ready", wr_ready, 1);

      // Asynchronous reset mid-cycle discards queued data.
      push(2, 31'h5);
      req_in = 4'b0100;
      #1 check("pre_rst_io", io_in, 31'h5);
      #1 rst = 1'b0;
      #1;
      check("async_empty", ch_empty, 4'b1111);
      check("async_io", io_in, 0);
      #1 rst = 1'b1;
      step();
      check("post_rst_uf", underflow, 4'b0100);
      req_in  = '0;
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("clr_uf", underflow, 0);

      // Ordering through ch1.
      push(1, 31'h7FFF_FFFF);
      push(1, 31'd7);
      push(1, 31'h3FFF_FFFF);
      req_in = 4'b0010;
      #1 check("ord0", io_in, 31'h7FFF_FFFF);
      step();
      check("ord1", io_in, 31'd7);
      step();
      check("ord2", io_in, 31'h3FFF_FFFF);
      step();
      check("ord_hold", io_in, 31'h3FFF_FFFF);
      req_in = '0;
      #1 check("ord_empty", ch_empty[1], 1);
      check("ord_no_uf", underflow, 0);

      // Fill ch0 to FDEPTH, check per-channel back-pressure.
      for (int i = 0; i < FDEPTH; i++) push(0, 31'(100 + i));
      wr_ch = 2'd0;
      #1 check("full_ready0", wr_ready, 0);
      wr_ch = 2'd3;
      #1 check("full_ready3", wr_ready, 1);
      wr_ch    = 2'd0;
      wr_data  = 31'd999;
      wr_valid = 1'b1;
      req_in   = 4'b0001;
      #1 check("full_pop_io", io_in, 31'd100);
      check("full_pop_ready", wr_ready, 0);
      step();
      wr_valid = 1'b0;
      for (int i = 1; i < FDEPTH; i++) begin
         check($sformatf("drain%0d", i), io_in, 31'(100 + i));
         step();
      end
      req_in = '0;
      #1 check("drain_empty", ch_empty[0], 1);
      check("drain_no_uf", underflow, 0);

      // Simultaneous write and pop on ch3 holding one value.
      push(3, 31'd9);
      wr_ch    = 2'd3;
      wr_data  = 31'd10;
      wr_valid = 1'b1;
      req_in   = 4'b1000;
      #1 check("sim_io", io_in, 31'd9);
      step();
      wr_valid = 1'b0;
      check("sim_next", io_in, 31'd10);
      check("sim_nonempty", ch_empty[3], 0);
      step();
      req_in = '0;
      #1 check("sim_cnt1", ch_empty[3], 1);

      // Write and pop on empty ch3: underflow, write still stored.
      wr_data  = 31'd11;
      wr_valid = 1'b1;
      req_in   = 4'b1000;
      #1 check("sim_empty_io", io_in, 31'd10);
      step();
      wr_valid = 1'b0;
      check("sim_empty_uf", underflow, 4'b1000);
      check("sim_empty_io2", io_in, 31'd11);
      step();
      req_in  = '0;
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("sim_clr", underflow, 0);
      check("sim_drained", ch_empty, 4'b1111);

      // Underflow shows the hold value; set beats clear.
      push(2, 31'd42);
      req_in = 4'b0100;
      #1 check("hold_pop", io_in, 31'd42);
      step();
      check("hold_io", io_in, 31'd42);
      step();
      check("hold_uf", underflow, 4'b0100);
      req_in  = '0;
      clr_err = 1'b1;
      step();
      check("hold_clr", underflow, 0);
      req_in = 4'b0100;
      step();
      check("set_wins", underflow, 4'b0100);
      req_in  = '0;
      step();
      clr_err = 1'b0;

      // Multi-request pops nothing.
      push(0, 31'd1);
      push(1, 31'd2);
      req_in = 4'b0011;
      #1 check("multi_io", io_in, 0);
      step();
      req_in = '0;
      check("multi_flag", multi_req, 1);
      check("multi_empty", ch_empty, 4'b1100);
      check("multi_no_uf", underflow, 0);
      req_in = 4'b0001;
      #1 check("multi_keep0", io_in, 31'd1);
      step();
      req_in = 4'b0010;
      #1 check("multi_keep1", io_in, 31'd2);
      step();
      req_in  = '0;
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("multi_clr", multi_req, 0);
      check("final_empty", ch_empty, 4'b1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
